// File: rtl/prio_clr_acc.sv
// Purpose : per-channel add/accumulate register with prioritised clears (clr_hi > clr_lo > en > hold).
// Latency : one clk from an accepted update or clear to q/valid/ovf/phase; async reset acts immediately.
// Backpres: none; every channel accepts an update on any edge with en=1 and no clear.
// Option  : define PRIO_CLR_ACC_SAT_EN to saturate q to all ones on carry-out instead of wrapping.
module prio_clr_acc #(
  parameter int WIDTH = 8,
  parameter int CH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH*WIDTH-1:0]   a,
  input  logic [CH*WIDTH-1:0]   b,
  input  logic [CH-1:0]         en,
  input  logic [CH-1:0]         clr_hi,
  input  logic [CH-1:0]         clr_lo,
  input  logic                  mode,
  output logic [CH*WIDTH-1:0]   q,
  output logic [CH-1:0]         valid,
  output logic [CH-1:0]         ovf,
  output logic [CH-1:0]         phase
);

  // Channel state: IDLE = no result yet, RUN = holding a result, OVF = sticky carry seen.
  // The unused code 2'b11 is decoded as IDLE so a corrupted register recovers on its own.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVF  = 2'b10
  } state_t;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [WIDTH-1:0] a_dat;
    logic [WIDTH-1:0] b_dat;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] upd_dat;
    logic [WIDTH:0]   sum;
    logic             carry;
    state_t           st_r;
    state_t           st_d;
    state_t           st_cur;
    logic             ph_r;
    logic             ph_d;
    logic             vld_r;
    logic             ovf_r;

    assign a_dat = a[i*WIDTH +: WIDTH];
    assign b_dat = b[i*WIDTH +: WIDTH];

    // Widened sum: mode=0 loads a+b, mode=1 accumulates onto the current q (b ignored).
    always_comb begin
      sum = '0;
      if (mode) begin
        sum = {1'b0, q_r} + {1'b0, a_dat};
      end else begin
        sum = {1'b0, a_dat} + {1'b0, b_dat};
      end
    end

    assign carry = sum[WIDTH];

`ifdef PRIO_CLR_ACC_SAT_EN
    // On carry the stored value clamps at full scale.
    assign upd_dat = carry ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    // On carry the stored value wraps to the low bits of the sum.
    assign upd_dat = sum[WIDTH-1:0];
`endif

    // Fold the illegal state code back onto IDLE before any decision is taken.
    always_comb begin
      st_cur = IDLE;
      case (st_r)
        RUN:     st_cur = RUN;
        OVF:     st_cur = OVF;
        default: st_cur = IDLE;
      endcase
    end

    // Next-state and next-data selection in priority order clr_hi > clr_lo > en > hold.
    always_comb begin
      q_d  = q_r;
      st_d = st_cur;
      ph_d = ph_r;
      if (clr_hi[i]) begin
        q_d  = '0;
        st_d = IDLE;
        ph_d = 1'b0;
      end else if (clr_lo[i]) begin
        // Low-priority clear empties the data but cannot erase a recorded overflow.
        q_d  = '0;
        st_d = (st_cur == OVF) ? OVF : IDLE;
      end else if (en[i]) begin
        q_d  = upd_dat;
        ph_d = ~ph_r;
        case (st_cur)
          OVF:     st_d = OVF;
          default: st_d = carry ? OVF : RUN;
        endcase
      end
    end

    // Channel registers; valid/ovf get their own flops so no output is a decode of state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_r   <= '0;
        st_r  <= IDLE;
        ph_r  <= 1'b0;
        vld_r <= 1'b0;
        ovf_r <= 1'b0;
      end else begin
        q_r   <= q_d;
        st_r  <= st_d;
        ph_r  <= ph_d;
        vld_r <= (st_d != IDLE);
        ovf_r <= (st_d == OVF);
      end
    end

    assign q[i*WIDTH +: WIDTH] = q_r;
    assign valid[i]            = vld_r;
    assign ovf[i]              = ovf_r;
    assign phase[i]            = ph_r;
  end

endmodule

// File: tb/tb_prio_clr_acc.sv
// Purpose : self-checking bench for prio_clr_acc (WIDTH=8, CH=2) against a rule-level model.
// Latency : model commits on each rising edge; outputs are sampled 1 time unit after it.
// Backpres: not applicable; stimulus is directed scenarios plus a randomized run.
module tb_prio_clr_acc;
  localparam int W    = 8;
  localparam int N    = 2;
  localparam int FULL = 1 << W;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] a;
  logic [N*W-1:0] b;
  logic [N-1:0]   en;
  logic [N-1:0]   clr_hi;
  logic [N-1:0]   clr_lo;
  logic           mode;
  logic [N*W-1:0] q;
  logic [N-1:0]   valid;
  logic [N-1:0]   ovf;
  logic [N-1:0]   phase;

  int total;
  int bad;

  // Model: value, status (0 empty, 1 has result, 2 overflowed) and phase per channel.
  int m_q[N];
  int m_st[N];
  bit m_ph[N];

  prio_clr_acc #(.WIDTH(W), .CH(N)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
    .clr_hi(clr_hi), .clr_lo(clr_lo), .mode(mode),
    .q(q), .valid(valid), .ovf(ovf), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] exp_q();
    logic [N*W-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*W +: W] = W'(m_q[c]);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = (m_st[c] != 0);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_ovf();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = (m_st[c] == 2);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_phase();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = m_ph[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_q[c] = 0; m_st[c] = 0; m_ph[c] = 1'b0;
    end
  endtask

  // One rising edge: evaluate the rules on pre-edge inputs, commit after the edge.
  task automatic tick();
    int nq[N];
    int nst[N];
    bit nph[N];
    int ai, bi, s;
    bit carry;
    for (int c = 0; c < N; c++) begin
      ai = int'(a[c*W +: W]);
      bi = int'(b[c*W +: W]);
      nq[c] = m_q[c]; nst[c] = m_st[c]; nph[c] = m_ph[c];
      if (clr_hi[c]) begin
        nq[c] = 0; nst[c] = 0; nph[c] = 1'b0;
      end else if (clr_lo[c]) begin
        nq[c] = 0;
        if (m_st[c] != 2) nst[c] = 0;
      end else if (en[c]) begin
        s = mode ? (m_q[c] + ai) : (ai + bi);
        carry = (s >= FULL);
`ifdef PRIO_CLR_ACC_SAT_EN
        nq[c] = carry ? FULL - 1 : s;
`else
        nq[c] = s % FULL;
`endif
        if (m_st[c] != 2) nst[c] = carry ? 2 : 1;
        nph[c] = ~m_ph[c];
      end
    end
    @(posedge clk);
    if (rst_n) begin
      for (int c = 0; c < N; c++) begin
        m_q[c] = nq[c]; m_st[c] = nst[c]; m_ph[c] = nph[c];
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    en = '0; clr_hi = '0; clr_lo = '0; mode = 1'b0; a = '0; b = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (q !== exp_q()) begin bad++; $display("FAIL reset_q got=%h want=%h", q, exp_q()); end
    total++; if (valid !== exp_valid()) begin bad++; $display("FAIL reset_valid got=%b want=%b", valid, exp_valid()); end
    total++; if (ovf !== exp_ovf()) begin bad++; $display("FAIL reset_ovf got=%b want=%b", ovf, exp_ovf()); end
    total++; if (phase !== exp_phase()) begin bad++; $display("FAIL reset_phase got=%b want=%b", phase, exp_phase()); end
    @(posedge clk); #1;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_load();
    idle_inputs();
    a[7:0] = 8'h12; b[7:0] = 8'h34; en = 2'b01;
    a[15:8] = 8'($urandom); b[15:8] = 8'($urandom);
    tick();
    total++; if (q[7:0] !== 8'h46) begin bad++; $display("FAIL load_q0 got=%h want=46", q[7:0]); end
    total++; if (q !== exp_q()) begin bad++; $display("FAIL load_q got=%h want=%h", q, exp_q()); end
    total++; if (valid !== exp_valid()) begin bad++; $display("FAIL load_valid got=%b want=%b", valid, exp_valid()); end
    total++; if (phase !== exp_phase()) begin bad++; $display("FAIL load_phase got=%b want=%b", phase, exp_phase()); end
  endtask

  task automatic test_acc_ovf();
    logic [7:0] want;
    idle_inputs();
    a[7:0] = 8'hF0; en = 2'b01;
    tick();
    total++; if (q[7:0] !== 8'hF0) begin bad++; $display("FAIL acc_pre got=%h want=f0", q[7:0]); end
    mode = 1'b1; a[7:0] = 8'h20; b[7:0] = 8'($urandom);
    tick();
`ifdef PRIO_CLR_ACC_SAT_EN
    want = 8'hFF;
`else
    want = 8'h10;
`endif
    total++; if (q[7:0] !== want) begin bad++; $display("FAIL acc_ovf_q got=%h want=%h", q[7:0], want); end
    total++; if (ovf !== exp_ovf() || ovf[0] !== 1'b1) begin bad++; $display("FAIL acc_ovf_flag got=%b want=%b", ovf, exp_ovf()); end
    total++; if (q !== exp_q()) begin bad++; $display("FAIL acc_q got=%h want=%h", q, exp_q()); end
  endtask

  task automatic test_priority();
    idle_inputs();
    a[15:8] = 8'h05; b[15:8] = 8'h07; en = 2'b10;
    tick();
    clr_hi = 2'b10; clr_lo = 2'b10; en = 2'b10; a[15:8] = 8'h33;
    tick();
    total++; if (q[15:8] !== 8'h00) begin bad++; $display("FAIL prio_hi_q got=%h want=00", q[15:8]); end
    total++; if (valid[1] !== 1'b0 || phase[1] !== 1'b0) begin bad++; $display("FAIL prio_hi_state got=v%b p%b want=v0 p0", valid[1], phase[1]); end
    idle_inputs();
    a[15:8] = 8'hFF; b[15:8] = 8'hFF; en = 2'b10;
    tick();
    total++; if (ovf !== exp_ovf()) begin bad++; $display("FAIL prio_ovf got=%b want=%b", ovf, exp_ovf()); end
    idle_inputs();
    clr_lo = 2'b10; en = 2'b10; a[15:8] = 8'h01;
    tick();
    total++; if (q[15:8] !== 8'h00 || ovf[1] !== 1'b1) begin bad++; $display("FAIL prio_lo_ovf got=q%h o%b want=q00 o1", q[15:8], ovf[1]); end
    total++; if (phase !== exp_phase() || valid !== exp_valid()) begin bad++; $display("FAIL prio_lo_misc got=p%b v%b want=p%b v%b", phase, valid, exp_phase(), exp_valid()); end
  endtask

  task automatic test_hold();
    logic [N*W-1:0] q0;
    logic [N-1:0] v0, o0, p0;
    idle_inputs();
    q0 = q; v0 = valid; o0 = ovf; p0 = phase;
    for (int k = 0; k < 5; k++) begin
      a = N*W'($urandom); b = N*W'($urandom); mode = k[0];
      tick();
      total++; if (q !== exp_q() || q !== q0) begin bad++; $display("FAIL hold_q[%0d] got=%h want=%h", k, q, exp_q()); end
      total++; if ({valid, ovf, phase} !== {v0, o0, p0}) begin bad++; $display("FAIL hold_flags[%0d] got=%b want=%b", k, {valid, ovf, phase}, {v0, o0, p0}); end
    end
    for (int k = 0; k < 4; k++) begin
      a = N*W'($urandom); b = N*W'($urandom); mode = 1'($urandom); en = 2'b01;
      tick();
      total++; if (q[15:8] !== q0[15:8] || {valid[1], ovf[1], phase[1]} !== {v0[1], o0[1], p0[1]}) begin
        bad++; $display("FAIL indep_ch1[%0d] got=%h want=%h", k, q[15:8], q0[15:8]);
      end
      total++; if (q !== exp_q() || phase !== exp_phase()) begin bad++; $display("FAIL indep_ch0[%0d] got=%h want=%h", k, q, exp_q()); end
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    clr_hi = 2'b01;
    tick();
    clr_hi = '0; a[7:0] = 8'h12; b[7:0] = 8'h34; en = 2'b01;
    tick();
    total++; if (q[7:0] !== 8'h46 || valid[0] !== 1'b1) begin bad++; $display("FAIL mid_pre got=q%h v%b want=q46 v1", q[7:0], valid[0]); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (q !== '0 || valid !== '0 || ovf !== '0 || phase !== '0) begin
      bad++; $display("FAIL mid_rst got=q%h v%b o%b p%b want=all zero", q, valid, ovf, phase);
    end
    tick();
    #2 rst_n = 1'b1;
    idle_inputs();
    a[7:0] = 8'h01; b[7:0] = 8'h01; en = 2'b01;
    tick();
    total++; if (q[7:0] !== 8'h02) begin bad++; $display("FAIL mid_release got=%h want=02", q[7:0]); end
    total++; if (q !== exp_q() || valid !== exp_valid()) begin bad++; $display("FAIL mid_state got=%h want=%h", q, exp_q()); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      a = N*W'($urandom); b = N*W'($urandom); mode = 1'($urandom);
      for (int c = 0; c < N; c++) begin
        en[c]     = ($urandom_range(0, 3) != 0);
        clr_hi[c] = ($urandom_range(0, 15) == 0);
        clr_lo[c] = ($urandom_range(0, 9) == 0);
      end
      tick();
      total++; if ({q, valid, ovf, phase} !== {exp_q(), exp_valid(), exp_ovf(), exp_phase()}) begin
        bad++; $display("FAIL rand[%0d] got=q%h v%b o%b p%b want=q%h v%b o%b p%b", k,
                        q, valid, ovf, phase, exp_q(), exp_valid(), exp_ovf(), exp_phase());
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_reset();
    test_reset();
    test_load();
    test_acc_ovf();
    test_priority();
    test_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
